risc_cpu_bus: RTL and testbench
===============================

// Module: risc_cpu_bus
// PURPOSE
//   Parametrised next-generation accumulator CPU; replaces the fixed 8-bit/5-bit top.
//   Width and address space set by parameters. Memory is external, behind a req/ack
//   bus with arbitrary wait states. Adds resume-from-halt. Optional bus-timeout watchdog.
//   Sits at SoC level: drives one memory/peripheral bus, reports halt to the testbench/system.
// PARAMETERS
//   DATA_W      8   accumulator/bus data width; must be >= ADDR_W+3
//   ADDR_W      5   address width; PC and operand width
//   RESET_PC    0   PC value after reset
//   TIMEOUT_CYC 16  wait cycles before bus error (only with CPU_BUS_TIMEOUT_EN)
// PORTS
//   clk        in   1       system clock, rising edge
//   rst_n      in   1       asynchronous, active-low reset
//   mem_req    out  1       bus request; held until ack
//   mem_we     out  1       1=write, 0=read; valid while mem_req
//   mem_addr   out  ADDR_W  bus address; valid while mem_req
//   mem_wdata  out  DATA_W  write data (=ACC); valid while mem_req&mem_we
//   mem_rdata  in   DATA_W  read data; sampled in the cycle mem_ack=1
//   mem_ack    in   1       transfer complete; may be high in the same cycle as req
//   resume     in   1       in HALT: leave halt, continue fetch at current PC
//   halt       out  1       1 while in S_HALT
//   pc         out  ADDR_W  debug: current PC
//   acc        out  DATA_W  debug: accumulator
//   bus_err    out  1       sticky bus timeout (tied 0 without macro)
// BEHAVIOUR
//   Instruction = mem word: opcode = [DATA_W-1 -: 3], operand = [ADDR_W-1:0], other bits ignored.
//   Reset (async): state=S_FETCH, PC=RESET_PC, ACC=0, IR=0, all outputs 0 (mem_req drops at once).
//   mem_req = state in {FETCH,MEMRD,MEMWR}. mem_addr/we/wdata stable until the ack cycle.
//   mem_ack while mem_req=0 is ignored. One transfer per ack.
//   S_FETCH: addr=PC, we=0. On ack: IR<=rdata, PC<=PC+1 (mod 2^ADDR_W), ->S_DECODE.
//   S_DECODE (1 cycle, no bus):
//     HLT 000 -> S_HALT | SKZ 001: if ACC==0 PC<=PC+1 (wraps); ->S_FETCH
//     ADD 010, AND 011, XOR 100, LDA 101 -> S_MEMRD | STO 110 -> S_MEMWR
//     JMP 111: PC<=operand; ->S_FETCH
//   S_MEMRD: addr=operand, we=0. On ack: ACC<=ACC+rdata (carry dropped), ACC&rdata,
//     ACC^rdata or rdata; ->S_FETCH.
//   S_MEMWR: addr=operand, we=1, wdata=ACC. On ack ->S_FETCH.
//   S_HALT: halt=1; PC/ACC frozen; resume=1 -> S_FETCH next cycle (halt=0).
//     Resume ignored outside S_HALT.
//   Latency with zero-wait ack: ALU/LDA/STO 3 cycles, SKZ/JMP 2, HLT->halt 2 cycles.
//   Each wait state adds one cycle.
//   Back-to-back: MEMRD/MEMWR->FETCH keeps mem_req high; addr changes the cycle after ack.
// CONFIGURATION
//   CPU_BUS_TIMEOUT_EN defined:
//     - wait counter clears on each req start/ack; increments on each req&!ack cycle.
//     - If it reaches TIMEOUT_CYC: abort transfer (no IR/ACC/PC update), ->S_HALT, bus_err<=1.
//     - bus_err is sticky until reset. resume is ignored while bus_err=1.
//   CPU_BUS_TIMEOUT_EN undefined: no counter; waits forever for ack; bus_err=0 constant.
// STRUCTURE
//   cpu_pkg: opcode localparams (OP_HLT..OP_JMP), state encoding, OPC_W=3.
//   Sub-module cpu_alu (DATA_W): combinational ADD/AND/XOR/PASS_B, result + is_zero.
//   FSM, PC, IR, ACC and bus registers live in this module.
// TESTING (DATA_W=8, ADDR_W=5, zero-wait memory model unless stated)
//   1 mem[0]=LDA 0x10, mem[1]=ADD 0x11, mem[2]=STO 0x12, mem[3]=HLT, mem[10h]=05, mem[11h]=03
//     -> mem[12h]=08, halt=1, pc=4, acc=08.
//   2 LDA(FFh), ADD(01h), SKZ, JMP 0, HLT -> acc=00, JMP skipped, halts with pc=5.
//   3 Test 1 with random 0-5 wait states -> addr/we/wdata stable until ack, same final state.
//   4 JMP 1Fh, mem[1Fh]=SKZ with acc!=0 -> pc wraps 1Fh->00, fetch from 0.
//     HLT then resume pulse -> next fetch addr = pc.
//   5 rst_n low mid S_MEMWR (req=1) -> mem_req=0 same cycle, no write, pc=RESET_PC, acc=0.
//   6 (CPU_BUS_TIMEOUT_EN) ack held 0 on fetch -> after 16 wait cycles halt=1, bus_err=1;
//     resume ignored; reset clears bus_err.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode, FSM state and ALU operation definitions for the accumulator CPU.
package cpu_pkg;

  localparam int OPC_W = 3;

  localparam logic [OPC_W-1:0] OP_HLT = 3'd0;
  localparam logic [OPC_W-1:0] OP_SKZ = 3'd1;
  localparam logic [OPC_W-1:0] OP_ADD = 3'd2;
  localparam logic [OPC_W-1:0] OP_AND = 3'd3;
  localparam logic [OPC_W-1:0] OP_XOR = 3'd4;
  localparam logic [OPC_W-1:0] OP_LDA = 3'd5;
  localparam logic [OPC_W-1:0] OP_STO = 3'd6;
  localparam logic [OPC_W-1:0] OP_JMP = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEMRD,
    S_MEMWR,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_AND,
    ALU_XOR,
    ALU_PASS_B
  } alu_op_e;

  // LDA and every non-ALU opcode map onto a plain pass of the bus operand.
  function automatic alu_op_e alu_op_for(input logic [OPC_W-1:0] opc);
    alu_op_e op;
    case (opc)
      OP_ADD:  op = ALU_ADD;
      OP_AND:  op = ALU_AND;
      OP_XOR:  op = ALU_XOR;
      default: op = ALU_PASS_B;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational accumulator ALU: ADD (carry dropped), AND, XOR or pass of operand B.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  alu_op_e           op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              is_zero_o
);

  always_comb begin
    result_o = b_i;
    case (op_i)
      ALU_ADD:    result_o = a_i + b_i;
      ALU_AND:    result_o = a_i & b_i;
      ALU_XOR:    result_o = a_i ^ b_i;
      ALU_PASS_B: result_o = b_i;
      default:    result_o = b_i;
    endcase
  end

  assign is_zero_o = (result_o == '0);

endmodule

// File: rtl/risc_cpu_bus.sv
// Parametrised accumulator CPU driving a req/ack memory bus with arbitrary wait states.
// Optional bus-timeout watchdog enabled by defining CPU_BUS_TIMEOUT_EN.
module risc_cpu_bus
  import cpu_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 5,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              resume,
  output logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic              bus_err
);

  if (DATA_W < ADDR_W + OPC_W) begin : g_width_check
    $error("risc_cpu_bus: DATA_W must be at least ADDR_W+3");
  end
  if (TIMEOUT_CYC < 1) begin : g_timeout_check
    $error("risc_cpu_bus: TIMEOUT_CYC must be at least 1");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [OPC_W-1:0]  opc_q, opc_d;
  logic [ADDR_W-1:0] arg_q, arg_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              halt_q, halt_d;
  logic              xfer;
  logic              resume_ok;
  alu_op_e           alu_op;
  logic [DATA_W-1:0] alu_b, alu_result;
  logic              alu_zero;

`ifdef CPU_BUS_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              bus_err_q, bus_err_d;
  assign resume_ok = resume & ~bus_err_q;
  assign bus_err   = bus_err_q;
`else
  assign resume_ok = resume;
  assign bus_err   = 1'b0;
`endif

  // Acks are only honoured while a request is actually outstanding.
  assign xfer = mem_req_q & mem_ack;

  // Outside S_MEMRD the ALU passes ACC through, so is_zero doubles as the SKZ test.
  assign alu_op = (state_q == S_MEMRD) ? alu_op_for(opc_q) : ALU_PASS_B;
  assign alu_b  = (state_q == S_MEMRD) ? mem_rdata : acc_q;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i     (alu_op),
    .a_i      (acc_q),
    .b_i      (alu_b),
    .result_o (alu_result),
    .is_zero_o(alu_zero)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    opc_d   = opc_q;
    arg_d   = arg_q;
    case (state_q)
      S_FETCH: begin
        if (xfer) begin
          opc_d   = mem_rdata[DATA_W-1 -: OPC_W];
          arg_d   = mem_rdata[ADDR_W-1:0];
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opc_q)
          OP_HLT: state_d = S_HALT;
          OP_SKZ: begin
            if (alu_zero) pc_d = pc_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
          OP_JMP: begin
            pc_d    = arg_q;
            state_d = S_FETCH;
          end
          OP_STO:  state_d = S_MEMWR;
          default: state_d = S_MEMRD;
        endcase
      end
      S_MEMRD: begin
        if (xfer) begin
          acc_d   = alu_result;
          state_d = S_FETCH;
        end
      end
      S_MEMWR: if (xfer) state_d = S_FETCH;
      S_HALT:  if (resume_ok) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase

`ifdef CPU_BUS_TIMEOUT_EN
    wait_d    = wait_q;
    bus_err_d = bus_err_q;
    if (!mem_req_q || mem_ack) begin
      wait_d = '0;
    end else if (wait_q == WAIT_W'(TIMEOUT_CYC - 1)) begin
      state_d   = S_HALT;
      wait_d    = '0;
      bus_err_d = 1'b1;
    end else begin
      wait_d = wait_q + WAIT_W'(1);
    end
`endif

    // Bus outputs are registered from the next state so they stay steady across wait states.
    mem_req_d   = state_d inside {S_FETCH, S_MEMRD, S_MEMWR};
    mem_we_d    = (state_d == S_MEMWR);
    mem_addr_d  = (state_d == S_FETCH) ? pc_d : arg_d;
    mem_wdata_d = (state_d == S_MEMWR) ? acc_d : '0;
    halt_d      = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      acc_q       <= '0;
      opc_q       <= '0;
      arg_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      halt_q      <= 1'b0;
`ifdef CPU_BUS_TIMEOUT_EN
      wait_q      <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      opc_q       <= opc_d;
      arg_q       <= arg_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      halt_q      <= halt_d;
`ifdef CPU_BUS_TIMEOUT_EN
      wait_q      <= wait_d;
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign halt      = halt_q;
  assign pc        = pc_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_risc_cpu_bus.sv
// Bench for risc_cpu_bus: wait-state memory model plus an instruction-level reference CPU.
// Exercises the CPU_BUS_TIMEOUT_EN watchdog when that macro is defined.
module tb_risc_cpu_bus;

  typedef struct packed {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
  } txn_t;

  typedef struct {
    string           name;
    logic [7:0][7:0] code;
    int              nDat;
    logic [3:0][4:0] dAddr;
    logic [3:0][7:0] dVal;
    int              maxWait;
    logic [4:0]      expPc;
    logic [7:0]      expAcc;
    logic [4:0]      chkAddr;
    logic [7:0]      chkVal;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_req, mem_we, mem_ack, resume, halt, bus_err;
  logic [4:0] mem_addr, pc;
  logic [7:0] mem_wdata, mem_rdata, acc;

  logic [7:0] mem[32];
  logic [7:0] modMem[32];
  txn_t       dutLog[$];
  txn_t       expLog[$];
  logic [4:0] expPc;
  logic [7:0] expAcc;
  int         expCycles;
  bit         modelHalted;

  int  vectors = 0;
  int  miscompares = 0;
  int  maxWait = 0;
  int  injectedWaits = 0;
  bit  holdAck = 1'b0;
  bit  inXfer = 1'b0;
  int  waitLeft = 0;
  txn_t cur;

  vec_t vecs[5];

  always #5 clk = ~clk;

  risc_cpu_bus #(.DATA_W(8), .ADDR_W(5), .RESET_PC(5'd0), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .resume(resume),
    .halt(halt), .pc(pc), .acc(acc), .bus_err(bus_err)
  );

  task automatic checkOutput(input string what, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, got, exp);
    end
  endtask

  // Memory responder: random wait states, checks request stability, logs completed transfers.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
  end
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (!mem_req) begin
      inXfer = 1'b0;
    end else begin
      if (!inXfer) begin
        inXfer = 1'b1;
        cur = '{we: mem_we, addr: mem_addr, wdata: mem_we ? mem_wdata : 8'h00};
        if (holdAck) waitLeft = 1 << 30;
        else begin
          waitLeft = int'($urandom_range(maxWait, 0));
          injectedWaits += waitLeft;
        end
      end else begin
        checkOutput("bus-stable", {mem_we, mem_addr, mem_we ? mem_wdata : 8'h00}, cur);
      end
      if (waitLeft == 0) begin
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
        dutLog.push_back(cur);
        inXfer = 1'b0;
      end else begin
        waitLeft--;
      end
    end
  end

  // Instruction-level reference: interprets the program in modMem, zero-wait cycle cost.
  task automatic runModel();
    int p = 0;
    logic [7:0] a = 8'h00;
    logic [7:0] ins, d;
    logic [2:0] op;
    logic [4:0] arg;
    expCycles = 1;
    expLog.delete();
    modelHalted = 1'b0;
    for (int step = 0; step < 300 && !modelHalted; step++) begin
      ins = modMem[p];
      expLog.push_back('{we: 1'b0, addr: 5'(p), wdata: 8'h00});
      p = (p + 1) % 32;
      op = ins[7:5];
      arg = ins[4:0];
      case (op)
        3'd0: begin expCycles += 2; modelHalted = 1'b1; end
        3'd1: begin expCycles += 2; if (a == 8'h00) p = (p + 1) % 32; end
        3'd7: begin expCycles += 2; p = int'(arg); end
        3'd6: begin
          expCycles += 3;
          expLog.push_back('{we: 1'b1, addr: arg, wdata: a});
          modMem[arg] = a;
        end
        default: begin
          expCycles += 3;
          expLog.push_back('{we: 1'b0, addr: arg, wdata: 8'h00});
          d = modMem[arg];
          case (op)
            3'd2: a = a + d;
            3'd3: a = a & d;
            3'd4: a = a ^ d;
            default: a = d;
          endcase
        end
      endcase
    end
    expPc = 5'(p);
    expAcc = a;
  endtask

  task automatic assertReset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    resume = 1'b0;
    #1;
  endtask

  // Releases reset with the current mem contents and runs until halt; cyc counts edges.
  task automatic applyStimulus(input int mw, output int cyc, output bit gotHalt);
    maxWait = mw;
    for (int i = 0; i < 32; i++) modMem[i] = mem[i];
    runModel();
    dutLog.delete();
    injectedWaits = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    gotHalt = 1'b0;
    for (cyc = 0; cyc < 3000; ) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (halt) begin gotHalt = 1'b1; break; end
    end
  endtask

  task automatic checkAgainstModel(input string name, input int cyc, input bit gotHalt);
    int n;
    checkOutput({name, " halted"}, 32'(gotHalt), 32'd1);
    checkOutput({name, " model-halts"}, 32'(modelHalted), 32'd1);
    checkOutput({name, " pc"}, 32'(pc), 32'(expPc));
    checkOutput({name, " acc"}, 32'(acc), 32'(expAcc));
    checkOutput({name, " cycles"}, 32'(cyc), 32'(expCycles + injectedWaits));
    checkOutput({name, " bus_err"}, 32'(bus_err), 32'd0);
    checkOutput({name, " req-in-halt"}, 32'(mem_req), 32'd0);
    checkOutput({name, " txn-count"}, 32'(dutLog.size()), 32'(expLog.size()));
    n = (dutLog.size() < expLog.size()) ? dutLog.size() : expLog.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s txn%0d", name, i), 32'(dutLog[i]), 32'(expLog[i]));
    for (int i = 0; i < 32; i++)
      checkOutput($sformatf("%s mem[%0h]", name, i), 32'(mem[i]), 32'(modMem[i]));
  endtask

  function automatic vec_t makeVec(input string name, input logic [63:0] code, input int nDat,
                                   input logic [19:0] dAddr, input logic [31:0] dVal,
                                   input int mw, input logic [4:0] ePc, input logic [7:0] eAcc,
                                   input logic [4:0] cAddr, input logic [7:0] cVal);
    vec_t v;
    v.name = name; v.code = code; v.nDat = nDat; v.dAddr = dAddr; v.dVal = dVal;
    v.maxWait = mw; v.expPc = ePc; v.expAcc = eAcc; v.chkAddr = cAddr; v.chkVal = cVal;
    return v;
  endfunction

  task automatic loadVec(input vec_t v);
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) mem[i] = v.code[i];
    for (int i = 0; i < v.nDat; i++) mem[v.dAddr[i]] = v.dVal[i];
  endtask

  initial begin
    int  cyc;
    bit  gotHalt;
    bit  found;
    int  writes;
    logic [2:0] op;
    logic [4:0] arg;

    resume = 1'b0;
    vecs[0] = makeVec("lda-add-sto", 64'h00000000_00D251B0, 2, {5'h0, 5'h0, 5'h11, 5'h10},
                      {8'h0, 8'h0, 8'h03, 8'h05}, 0, 5'h04, 8'h08, 5'h12, 8'h08);
    vecs[1] = makeVec("skz-skip", 64'h00000000_E02051B0, 2, {5'h0, 5'h0, 5'h11, 5'h10},
                      {8'h0, 8'h0, 8'h01, 8'hFF}, 0, 5'h05, 8'h00, 5'h11, 8'h01);
    vecs[2] = makeVec("lda-add-sto-waits", 64'h00000000_00D251B0, 2, {5'h0, 5'h0, 5'h11, 5'h10},
                      {8'h0, 8'h0, 8'h03, 8'h05}, 5, 5'h04, 8'h08, 5'h12, 8'h08);
    vecs[3] = makeVec("xor-and", 64'h00000000_D37291B0, 3, {5'h0, 5'h12, 5'h11, 5'h10},
                      {8'h0, 8'h0F, 8'hFF, 8'h5A}, 2, 5'h05, 8'h05, 5'h13, 8'h05);
    vecs[4] = makeVec("jmp-wrap", 64'h00000000_00FFC0B1, 2, {5'h0, 5'h0, 5'h1F, 5'h11},
                      {8'h0, 8'h0, 8'h20, 8'hE5}, 0, 5'h06, 8'hE5, 5'h00, 8'hE5);

    assertReset();
    checkOutput("reset mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset halt", 32'(halt), 32'd0);
    checkOutput("reset pc", 32'(pc), 32'd0);
    checkOutput("reset acc", 32'(acc), 32'd0);

    for (int v = 0; v < 5; v++) begin
      assertReset();
      loadVec(vecs[v]);
      applyStimulus(vecs[v].maxWait, cyc, gotHalt);
      checkOutput({vecs[v].name, " table-pc"}, 32'(pc), 32'(vecs[v].expPc));
      checkOutput({vecs[v].name, " table-acc"}, 32'(acc), 32'(vecs[v].expAcc));
      checkOutput({vecs[v].name, " table-mem"}, 32'(mem[vecs[v].chkAddr]), 32'(vecs[v].chkVal));
      checkAgainstModel(vecs[v].name, cyc, gotHalt);
    end

    // Resume from the jmp-wrap halt: fetch continues at pc 6, which holds another HLT.
    resume = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resume = 1'b0;
    checkOutput("resume halt-drops", 32'(halt), 32'd0);
    checkOutput("resume req", 32'(mem_req), 32'd1);
    checkOutput("resume fetch-addr", 32'(mem_addr), 32'h06);
    gotHalt = 1'b0;
    for (int i = 0; i < 20 && !gotHalt; i++) begin
      @(posedge clk);
      @(negedge clk);
      gotHalt = halt;
    end
    checkOutput("resume rehalt", 32'(gotHalt), 32'd1);
    checkOutput("resume pc", 32'(pc), 32'h07);
    checkOutput("resume acc", 32'(acc), 32'hE5);

    for (int r = 0; r < 8; r++) begin
      assertReset();
      for (int i = 0; i < 32; i++) mem[i] = (i >= 16) ? 8'($urandom) : 8'h00;
      for (int i = 0; i < 12; i++) begin
        op = 3'($urandom_range(7, 1));
        arg = (op == 3'd7) ? 5'($urandom_range(12, i + 1)) : 5'(16 + $urandom_range(15, 0));
        mem[i] = {op, arg};
      end
      applyStimulus(r % 4, cyc, gotHalt);
      checkAgainstModel($sformatf("rand%0d", r), cyc, gotHalt);
    end

    // Reset asserted while a store request is on the bus.
    assertReset();
    loadVec(vecs[0]);
    maxWait = 0;
    dutLog.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk);
      #1;
      found = mem_req & mem_we;
    end
    checkOutput("rst-mid-wr reached", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst-mid-wr req", 32'(mem_req), 32'd0);
    checkOutput("rst-mid-wr we", 32'(mem_we), 32'd0);
    checkOutput("rst-mid-wr pc", 32'(pc), 32'd0);
    checkOutput("rst-mid-wr acc", 32'(acc), 32'd0);
    repeat (3) @(posedge clk);
    writes = 0;
    foreach (dutLog[i]) if (dutLog[i].we) writes++;
    checkOutput("rst-mid-wr no-write", 32'(writes), 32'd0);
    checkOutput("rst-mid-wr mem12", 32'(mem[18]), 32'h00);

    assertReset();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    holdAck = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
`ifdef CPU_BUS_TIMEOUT_EN
    gotHalt = 1'b0;
    for (cyc = 0; cyc < 100 && !gotHalt; ) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      gotHalt = halt;
    end
    checkOutput("timeout halted", 32'(gotHalt), 32'd1);
    checkOutput("timeout cycles", 32'(cyc), 32'd17);
    checkOutput("timeout bus_err", 32'(bus_err), 32'd1);
    checkOutput("timeout pc", 32'(pc), 32'd0);
    checkOutput("timeout req", 32'(mem_req), 32'd0);
    resume = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resume = 1'b0;
    checkOutput("timeout resume-ignored", 32'(halt), 32'd1);
    checkOutput("timeout err-sticky", 32'(bus_err), 32'd1);
    assertReset();
    checkOutput("timeout reset-clears", 32'(bus_err), 32'd0);
`else
    repeat (40) @(posedge clk);
    @(negedge clk);
    checkOutput("no-ack still-waiting", 32'(halt), 32'd0);
    checkOutput("no-ack req-held", 32'(mem_req), 32'd1);
    checkOutput("no-ack addr", 32'(mem_addr), 32'd0);
    checkOutput("no-ack bus_err", 32'(bus_err), 32'd0);
    checkOutput("no-ack pc", 32'(pc), 32'd0);
    assertReset();
`endif
    holdAck = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
